// File: rtl/avg_if.sv
// Handshake/bus bundle for avg_engine: strobes and sample in, average and status out.
// Strobes are single-cycle pulses sampled on the rising clock edge; there is no ready/back-pressure.
interface avg_if #(
  parameter int DATA_W = 12
);
  logic              shift_avg;
  logic              calc_avg;
  logic [DATA_W-1:0] sample_in;
  logic [DATA_W-1:0] avg_out;
  logic              avg_done;
  logic              busy;
  logic              ovr;
  logic [1:0]        dbg_state;

  modport master (
    output shift_avg, calc_avg, sample_in,
    input  avg_out, avg_done, busy, ovr, dbg_state
  );

  modport slave (
    input  shift_avg, calc_avg, sample_in,
    output avg_out, avg_done, busy, ovr, dbg_state
  );
endinterface

// File: rtl/avg_engine.sv
// Moving-window averager: DEPTH-entry shift buffer summed serially, divided by shift.
// Define AVG_ROUND_EN for round-half-up division; default build truncates.
module avg_engine #(
  parameter int DATA_W     = 12,
  parameter int DEPTH_LOG2 = 3
) (
  input logic   clk,
  input logic   n_rst,
  avg_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = DATA_W + DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;

  state_t                  state;
  logic [DATA_W-1:0]       win [DEPTH];
  logic [AW-1:0]           acc;
  logic [DEPTH_LOG2-1:0]   idx;
  logic [DATA_W-1:0]       avg_q;
  logic                    done_q;
  logic                    busy_q;
  logic                    ovr_q;
  logic [AW-1:0]           sum_adj;
  logic [DATA_W-1:0]       result;

`ifdef AVG_ROUND_EN
  assign sum_adj = acc + AW'(DEPTH / 2);
`else
  assign sum_adj = acc;
`endif
  assign result = DATA_W'(sum_adj >> DEPTH_LOG2);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= IDLE;
      acc    <= '0;
      idx    <= '0;
      avg_q  <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      ovr_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
    end else begin
      // Any strobe outside IDLE is dropped and only recorded in the sticky flag.
      if (state != IDLE && (bus.shift_avg || bus.calc_avg)) ovr_q <= 1'b1;
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.shift_avg) begin
            win[0] <= bus.sample_in;
            for (int i = 1; i < DEPTH; i++) win[i] <= win[i-1];
          end
          if (bus.calc_avg) begin
            acc    <= '0;
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc + AW'(win[idx]);
          idx <= idx + 1'b1;
          if (idx == DEPTH_LOG2'(DEPTH - 1)) state <= DIVIDE;
        end
        DIVIDE: begin
          avg_q  <= result;
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.avg_out   = avg_q;
  assign bus.avg_done  = done_q;
  assign bus.busy      = busy_q;
  assign bus.ovr       = ovr_q;
  assign bus.dbg_state = state;
endmodule
